// File: rtl/pipe_mips32_core.sv
// Five-stage in-order MIPS32-subset core (IF, ID, EX, MEM, WB) with its own
// 32x32 register file and a unified word-addressed instruction/data memory.
// Hazards are resolved in hardware: EX/MEM and MEM/WB forwarding into EX,
// write-through from WB into the ID register read, a one-cycle load-use stall,
// and branch resolution in EX with a two-slot squash on a taken branch.
module pipe_mips32_core #(
  parameter int MEM_WORDS = 1024
) (
  input  logic clk,
  input  logic rst_n,
  output logic halted
);

  localparam int AW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

  localparam logic [5:0] OP_ADD   = 6'd0;
  localparam logic [5:0] OP_SUB   = 6'd1;
  localparam logic [5:0] OP_AND   = 6'd2;
  localparam logic [5:0] OP_OR    = 6'd3;
  localparam logic [5:0] OP_SLT   = 6'd4;
  localparam logic [5:0] OP_MUL   = 6'd5;
  localparam logic [5:0] OP_LW    = 6'd8;
  localparam logic [5:0] OP_SW    = 6'd9;
  localparam logic [5:0] OP_ADDI  = 6'd10;
  localparam logic [5:0] OP_SUBI  = 6'd11;
  localparam logic [5:0] OP_SLTI  = 6'd12;
  localparam logic [5:0] OP_BNEQZ = 6'd13;
  localparam logic [5:0] OP_BEQZ  = 6'd14;
  localparam logic [5:0] OP_HLT   = 6'd63;

  // Architectural state, visible by hierarchical name for preload and inspection.
  logic [31:0] Reg [0:31];
  logic [31:0] Mem [0:MEM_WORDS-1];
  logic [31:0] PC;
  logic        HALTED;
  logic        TAKEN_BRANCH;

  // IF/ID
  logic        if_id_valid;
  logic [31:0] if_id_ir;
  logic [31:0] if_id_pc;
  // ID/EX
  logic        id_ex_valid;
  logic [5:0]  id_ex_op;
  logic [4:0]  id_ex_rs;
  logic [4:0]  id_ex_rt;
  logic [4:0]  id_ex_dest;
  logic        id_ex_wr;
  logic [31:0] id_ex_a;
  logic [31:0] id_ex_b;
  logic [31:0] id_ex_imm;
  logic [31:0] id_ex_pc;
  // EX/MEM
  logic        ex_mem_valid;
  logic [5:0]  ex_mem_op;
  logic [31:0] ex_mem_res;
  logic [31:0] ex_mem_b;
  logic [4:0]  ex_mem_dest;
  logic        ex_mem_wr;
  // MEM/WB
  logic        mem_wb_valid;
  logic [31:0] mem_wb_res;
  logic [4:0]  mem_wb_dest;
  logic        mem_wb_wr;
  logic        mem_wb_halt;
  // Set once an HLT has left ID: fetch stays frozen until reset.
  logic        fetch_stop;

  // Decode / hazard signals
  logic [5:0]  id_op;
  logic [4:0]  id_rs, id_rt, id_rd, id_dest;
  logic [31:0] id_imm, id_a, id_b;
  logic        id_wr, id_halt, load_use, wb_we;
  // Execute signals
  logic [31:0] fwd_a, fwd_b, alu_res, branch_target;
  // Memory-stage signals
  logic [31:0] mem_result;
  logic        store_en;

  // Word addresses wrap modulo the memory depth.
  function automatic logic [AW-1:0] word_index(input logic [31:0] addr);
    return AW'(addr % 32'(MEM_WORDS));
  endfunction

  function automatic logic is_rr(input logic [5:0] op);
    return op <= OP_MUL;
  endfunction

  function automatic logic is_rm(input logic [5:0] op);
    return (op >= OP_ADDI) && (op <= OP_SLTI);
  endfunction

  function automatic logic writes_reg(input logic [5:0] op);
    return is_rr(op) || is_rm(op) || (op == OP_LW);
  endfunction

  function automatic logic uses_rs(input logic [5:0] op);
    return is_rr(op) || is_rm(op) || (op == OP_LW) || (op == OP_SW) ||
           (op == OP_BNEQZ) || (op == OP_BEQZ);
  endfunction

  function automatic logic uses_rt(input logic [5:0] op);
    return is_rr(op) || (op == OP_SW);
  endfunction

  assign halted = HALTED;

  // Decode the IF/ID word, read operands with WB write-through, detect load-use.
  always_comb begin
    id_op   = if_id_ir[31:26];
    id_rs   = if_id_ir[25:21];
    id_rt   = if_id_ir[20:16];
    id_rd   = if_id_ir[15:11];
    id_imm  = {{16{if_id_ir[15]}}, if_id_ir[15:0]};
    id_wr   = writes_reg(id_op);
    id_dest = is_rr(id_op) ? id_rd : id_rt;
    wb_we   = mem_wb_valid && mem_wb_wr && (mem_wb_dest != 5'd0) && !HALTED;

    if (id_rs == 5'd0) begin
      id_a = 32'd0;
    end else if (wb_we && (mem_wb_dest == id_rs)) begin
      id_a = mem_wb_res;
    end else begin
      id_a = Reg[id_rs];
    end

    if (id_rt == 5'd0) begin
      id_b = 32'd0;
    end else if (wb_we && (mem_wb_dest == id_rt)) begin
      id_b = mem_wb_res;
    end else begin
      id_b = Reg[id_rt];
    end

    id_halt  = if_id_valid && (id_op == OP_HLT);
    load_use = if_id_valid && id_ex_valid && (id_ex_op == OP_LW) &&
               (id_ex_dest != 5'd0) &&
               ((uses_rs(id_op) && (id_rs == id_ex_dest)) ||
                (uses_rt(id_op) && (id_rt == id_ex_dest)));
  end

  // Forward EX operands from the youngest older producer (EX/MEM before MEM/WB).
  always_comb begin
    if (ex_mem_valid && ex_mem_wr && (ex_mem_op != OP_LW) &&
        (ex_mem_dest != 5'd0) && (ex_mem_dest == id_ex_rs)) begin
      fwd_a = ex_mem_res;
    end else if (mem_wb_valid && mem_wb_wr && (mem_wb_dest != 5'd0) &&
                 (mem_wb_dest == id_ex_rs)) begin
      fwd_a = mem_wb_res;
    end else begin
      fwd_a = id_ex_a;
    end

    if (ex_mem_valid && ex_mem_wr && (ex_mem_op != OP_LW) &&
        (ex_mem_dest != 5'd0) && (ex_mem_dest == id_ex_rt)) begin
      fwd_b = ex_mem_res;
    end else if (mem_wb_valid && mem_wb_wr && (mem_wb_dest != 5'd0) &&
                 (mem_wb_dest == id_ex_rt)) begin
      fwd_b = mem_wb_res;
    end else begin
      fwd_b = id_ex_b;
    end
  end

  // ALU result, branch decision and branch target for the instruction in EX.
  always_comb begin
    alu_res = 32'd0;
    case (id_ex_op)
      OP_ADD:  alu_res = fwd_a + fwd_b;
      OP_SUB:  alu_res = fwd_a - fwd_b;
      OP_AND:  alu_res = fwd_a & fwd_b;
      OP_OR:   alu_res = fwd_a | fwd_b;
      OP_SLT:  alu_res = ($signed(fwd_a) < $signed(fwd_b)) ? 32'd1 : 32'd0;
      OP_MUL:  alu_res = fwd_a * fwd_b;
      OP_ADDI: alu_res = fwd_a + id_ex_imm;
      OP_SUBI: alu_res = fwd_a - id_ex_imm;
      OP_SLTI: alu_res = ($signed(fwd_a) < $signed(id_ex_imm)) ? 32'd1 : 32'd0;
      OP_LW:   alu_res = fwd_a + id_ex_imm;
      OP_SW:   alu_res = fwd_a + id_ex_imm;
      default: alu_res = 32'd0;
    endcase

    branch_target = id_ex_pc + 32'd1 + id_ex_imm;
    if (id_ex_valid && (id_ex_op == OP_BNEQZ)) begin
      TAKEN_BRANCH = (fwd_a != 32'd0);
    end else if (id_ex_valid && (id_ex_op == OP_BEQZ)) begin
      TAKEN_BRANCH = (fwd_a == 32'd0);
    end else begin
      TAKEN_BRANCH = 1'b0;
    end
  end

  // Memory stage: load data selection and store enable.
  always_comb begin
    store_en = ex_mem_valid && (ex_mem_op == OP_SW) && !HALTED;
    if (ex_mem_op == OP_LW) begin
      mem_result = Mem[word_index(ex_mem_res)];
    end else begin
      mem_result = ex_mem_res;
    end
  end

  // Data memory write port; contents are not touched by reset.
  always_ff @(posedge clk) begin
    if (store_en) begin
      Mem[word_index(ex_mem_res)] <= ex_mem_b;
    end
  end

  // Register file write port (R0 writes are dropped via wb_we).
  always_ff @(posedge clk) begin
    if (wb_we) begin
      Reg[mem_wb_dest] <= mem_wb_res;
    end
  end

  // Pipeline registers, PC and halt state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      PC           <= 32'd0;
      HALTED       <= 1'b0;
      fetch_stop   <= 1'b0;
      if_id_valid  <= 1'b0;
      if_id_ir     <= 32'd0;
      if_id_pc     <= 32'd0;
      id_ex_valid  <= 1'b0;
      id_ex_op     <= 6'd0;
      id_ex_rs     <= 5'd0;
      id_ex_rt     <= 5'd0;
      id_ex_dest   <= 5'd0;
      id_ex_wr     <= 1'b0;
      id_ex_a      <= 32'd0;
      id_ex_b      <= 32'd0;
      id_ex_imm    <= 32'd0;
      id_ex_pc     <= 32'd0;
      ex_mem_valid <= 1'b0;
      ex_mem_op    <= 6'd0;
      ex_mem_res   <= 32'd0;
      ex_mem_b     <= 32'd0;
      ex_mem_dest  <= 5'd0;
      ex_mem_wr    <= 1'b0;
      mem_wb_valid <= 1'b0;
      mem_wb_res   <= 32'd0;
      mem_wb_dest  <= 5'd0;
      mem_wb_wr    <= 1'b0;
      mem_wb_halt  <= 1'b0;
    end else begin
      // Fetch: a taken branch wins over a halt or stall sitting in ID.
      if (TAKEN_BRANCH) begin
        PC          <= branch_target;
        if_id_valid <= 1'b0;
      end else if (id_halt || fetch_stop) begin
        if_id_valid <= 1'b0;
      end else if (load_use) begin
        if_id_valid <= if_id_valid;
      end else begin
        PC          <= PC + 32'd1;
        if_id_valid <= 1'b1;
        if_id_ir    <= Mem[word_index(PC)];
        if_id_pc    <= PC;
      end

      if (id_halt && !TAKEN_BRANCH) begin
        fetch_stop <= 1'b1;
      end

      // Decode -> execute; squashed or stalled slots become bubbles.
      if (TAKEN_BRANCH || load_use) begin
        id_ex_valid <= 1'b0;
      end else begin
        id_ex_valid <= if_id_valid;
      end
      id_ex_op   <= id_op;
      id_ex_rs   <= id_rs;
      id_ex_rt   <= id_rt;
      id_ex_dest <= id_dest;
      id_ex_wr   <= id_wr;
      id_ex_a    <= id_a;
      id_ex_b    <= id_b;
      id_ex_imm  <= id_imm;
      id_ex_pc   <= if_id_pc;

      ex_mem_valid <= id_ex_valid;
      ex_mem_op    <= id_ex_op;
      ex_mem_res   <= alu_res;
      ex_mem_b     <= fwd_b;
      ex_mem_dest  <= id_ex_dest;
      ex_mem_wr    <= id_ex_wr;

      mem_wb_valid <= ex_mem_valid;
      mem_wb_res   <= mem_result;
      mem_wb_dest  <= ex_mem_dest;
      mem_wb_wr    <= ex_mem_wr;
      mem_wb_halt  <= (ex_mem_op == OP_HLT);

      if (mem_wb_valid && mem_wb_halt) begin
        HALTED <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pipe_mips32_core.sv
// Bench for pipe_mips32_core: directed programs plus random straight-line
// programs, compared against an instruction-at-a-time reference interpreter.
module tb_pipe_mips32_core;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic halted;

  int passed = 0;
  int failed = 0;
  int total = 0;

  logic [31:0] mr [32];
  logic [31:0] mm [1024];
  int model_taken;
  int model_hlt_pc;
  int dut_taken;
  int cyc_a, cyc_b;

  pipe_mips32_core #(.MEM_WORDS(1024)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .halted(halted)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] enc_r(input int op, input int rs, input int rt, input int rd);
    return {op[5:0], rs[4:0], rt[4:0], rd[4:0], 11'd0};
  endfunction

  function automatic logic [31:0] enc_i(input int op, input int rs, input int rt, input int imm);
    return {op[5:0], rs[4:0], rt[4:0], imm[15:0]};
  endfunction

  // Hold the core in reset and give the model a clean state: Reg[k]=k, memory zero.
  task automatic begin_test();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 32; k++) mr[k] = 32'(k);
    for (int k = 0; k < 1024; k++) mm[k] = 32'd0;
  endtask

  task automatic load_prog(input logic [31:0] p[$]);
    for (int i = 0; i < p.size(); i++) mm[i] = p[i];
  endtask

  task automatic sync_dut();
    for (int k = 0; k < 32; k++) dut.Reg[k] = mr[k];
    for (int k = 0; k < 1024; k++) dut.Mem[k] = mm[k];
  endtask

  task automatic model_wr(input int r, input logic [31:0] v);
    if (r != 0) mr[r] = v;
  endtask

  // Sequential interpreter: one instruction at a time, no pipeline notion.
  task automatic run_model();
    int pc;
    logic [31:0] ir, a, b, imm, addr;
    logic [5:0] op;
    int rs, rt, rd;
    pc = 0;
    model_taken = 0;
    model_hlt_pc = -1;
    for (int step = 0; step < 4000; step++) begin
      ir = mm[pc % 1024];
      op = ir[31:26];
      rs = int'(ir[25:21]);
      rt = int'(ir[20:16]);
      rd = int'(ir[15:11]);
      a = (rs == 0) ? 32'd0 : mr[rs];
      b = (rt == 0) ? 32'd0 : mr[rt];
      imm = {{16{ir[15]}}, ir[15:0]};
      addr = (a + imm) % 32'd1024;
      if (op == 6'd63) begin
        model_hlt_pc = pc;
        break;
      end
      pc = pc + 1;
      case (op)
        6'd0:  model_wr(rd, a + b);
        6'd1:  model_wr(rd, a - b);
        6'd2:  model_wr(rd, a & b);
        6'd3:  model_wr(rd, a | b);
        6'd4:  model_wr(rd, ($signed(a) < $signed(b)) ? 32'd1 : 32'd0);
        6'd5:  model_wr(rd, a * b);
        6'd10: model_wr(rt, a + imm);
        6'd11: model_wr(rt, a - imm);
        6'd12: model_wr(rt, ($signed(a) < $signed(imm)) ? 32'd1 : 32'd0);
        6'd8:  model_wr(rt, mm[addr]);
        6'd9:  mm[addr] = b;
        6'd13: if (a != 32'd0) begin pc = pc + int'($signed(imm)); model_taken++; end
        6'd14: if (a == 32'd0) begin pc = pc + int'($signed(imm)); model_taken++; end
        default: ;
      endcase
    end
  endtask

  // Release reset and count clock edges until halted, with a bound.
  task automatic run_dut(input int limit, output int cycles);
    cycles = 0;
    dut_taken = 0;
    @(negedge clk);
    rst_n = 1'b1;
    while (halted !== 1'b1 && cycles < limit) begin
      @(posedge clk);
      #1;
      cycles++;
      if (dut.TAKEN_BRANCH === 1'b1) dut_taken++;
    end
    check("halt_reached", {31'd0, halted}, 32'd1);
  endtask

  task automatic compare_regs(input string tag);
    for (int k = 0; k < 32; k++)
      check($sformatf("%s_R%0d", tag, k), dut.Reg[k], mr[k]);
  endtask

  task automatic compare_mem(input string tag, input int lo, input int hi);
    for (int k = lo; k <= hi; k++)
      check($sformatf("%s_M%0d", tag, k), dut.Mem[k], mm[k]);
  endtask

  // After halting, ten more cycles must not move PC or change state.
  task automatic check_frozen(input string tag);
    repeat (10) @(posedge clk);
    #1;
    check({tag, "_pc_frozen"}, dut.PC, 32'(model_hlt_pc + 1));
  endtask

  initial begin
    logic [31:0] prog1[$];
    logic [31:0] prog[$];
    int n, kind, lim;

    prog1 = '{32'h2801000a, 32'h28020014, 32'h28030019, 32'h0ce77800, 32'h0ce77800,
              32'h00222000, 32'h0ce77800, 32'h00832800, 32'hfc000000};

    // Reset state
    #1;
    check("rst_pc", dut.PC, 32'd0);
    check("rst_halted_int", {31'd0, dut.HALTED}, 32'd0);
    check("rst_halted", {31'd0, halted}, 32'd0);
    check("rst_taken", {31'd0, dut.TAKEN_BRANCH}, 32'd0);

    // Program with filler instructions
    begin_test();
    load_prog(prog1);
    sync_dut();
    run_model();
    run_dut(100, cyc_a);
    check("t1_within_20", (cyc_a <= 20) ? 32'd1 : 32'd0, 32'd1);
    check("t1_R1", dut.Reg[1], 32'd10);
    check("t1_R2", dut.Reg[2], 32'd20);
    check("t1_R3", dut.Reg[3], 32'd25);
    check("t1_R4", dut.Reg[4], 32'd30);
    check("t1_R5", dut.Reg[5], 32'd55);
    compare_regs("t1");
    check_frozen("t1");

    // Same program, back-to-back dependencies
    begin_test();
    prog = '{32'h2801000a, 32'h28020014, 32'h28030019, 32'h00222000, 32'h00832800, 32'hfc000000};
    load_prog(prog);
    sync_dut();
    run_model();
    run_dut(100, cyc_a);
    check("t2_R4", dut.Reg[4], 32'd30);
    check("t2_R5", dut.Reg[5], 32'd55);
    compare_regs("t2");

    // Load-use: dependent ADDI costs exactly one extra cycle
    begin_test();
    mr[1] = 32'd120;
    mm[120] = 32'd85;
    prog = '{enc_i(8, 1, 2, 0), enc_i(10, 2, 3, 45), 32'hfc000000};
    load_prog(prog);
    sync_dut();
    run_model();
    run_dut(100, cyc_a);
    check("t3_R3", dut.Reg[3], 32'd130);
    check("t3_cycles", 32'(cyc_a), 32'd8);
    compare_regs("t3");
    begin_test();
    mr[1] = 32'd120;
    mm[120] = 32'd85;
    prog = '{enc_i(8, 1, 2, 0), enc_i(10, 4, 3, 45), 32'hfc000000};
    load_prog(prog);
    sync_dut();
    run_model();
    run_dut(100, cyc_b);
    check("t3_stall_delta", 32'(cyc_a - cyc_b), 32'd1);

    // Store
    begin_test();
    mr[1] = 32'd120;
    mr[3] = 32'd130;
    prog = '{enc_i(9, 1, 3, 1), 32'hfc000000};
    load_prog(prog);
    sync_dut();
    run_model();
    run_dut(100, cyc_a);
    check("t4_M121", dut.Mem[121], 32'd130);
    compare_mem("t4", 118, 124);

    // Factorial loop; the two slots after the branch must not write while it loops
    begin_test();
    mr[10] = 32'd200;
    mr[2] = 32'd1;
    mm[200] = 32'd7;
    prog = '{enc_i(8, 10, 3, 0), enc_r(5, 2, 3, 2), enc_i(11, 3, 3, 1), enc_i(13, 3, 0, -3),
             enc_i(10, 20, 20, 1), enc_i(10, 21, 21, 1), 32'hfc000000};
    load_prog(prog);
    sync_dut();
    run_model();
    run_dut(300, cyc_a);
    check("t5_R2", dut.Reg[2], 32'd5040);
    check("t5_R20", dut.Reg[20], 32'd21);
    check("t5_R21", dut.Reg[21], 32'd22);
    check("t5_taken_count", 32'(dut_taken), 32'(model_taken));
    check("t5_taken_six", 32'(dut_taken), 32'd6);
    compare_regs("t5");
    check_frozen("t5");

    // Reset in the middle of a run, then rerun
    begin_test();
    load_prog(prog1);
    sync_dut();
    run_model();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_pc_reset", dut.PC, 32'd0);
    check("t6_halted_reset", {31'd0, dut.HALTED}, 32'd0);
    check("t6_out_reset", {31'd0, halted}, 32'd0);
    run_dut(100, cyc_a);
    check("t6_R4", dut.Reg[4], 32'd30);
    check("t6_R5", dut.Reg[5], 32'd55);
    compare_regs("t6");

    // Random straight-line programs with forward branches, loads and stores
    for (int t = 0; t < 8; t++) begin
      begin_test();
      for (int k = 1; k < 8; k++) mr[k] = $urandom;
      for (int k = 100; k < 116; k++) mm[k] = $urandom;
      n = 24;
      prog = {};
      for (int i = 0; i < n - 1; i++) begin
        kind = int'($urandom_range(0, 9));
        case (kind)
          0, 1, 2, 9: prog.push_back(enc_r(int'($urandom_range(0, 5)), int'($urandom_range(0, 7)),
                                          int'($urandom_range(0, 7)), int'($urandom_range(0, 7))));
          3, 4: prog.push_back(enc_i(int'($urandom_range(10, 12)), int'($urandom_range(0, 7)),
                                     int'($urandom_range(0, 7)), int'($urandom_range(0, 65535))));
          5: prog.push_back(enc_i(8, 0, int'($urandom_range(0, 7)), 100 + int'($urandom_range(0, 15))));
          6: prog.push_back(enc_i(9, 0, int'($urandom_range(0, 7)), 100 + int'($urandom_range(0, 15))));
          7: begin
            lim = (n - 2 - i < 2) ? (n - 2 - i) : 2;
            prog.push_back(enc_i(int'($urandom_range(13, 14)), int'($urandom_range(0, 7)), 0,
                                 int'($urandom_range(0, lim))));
          end
          default: prog.push_back(enc_r(20, int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                                        int'($urandom_range(0, 7))));
        endcase
      end
      prog.push_back(32'hfc000000);
      load_prog(prog);
      sync_dut();
      run_model();
      run_dut(400, cyc_a);
      check($sformatf("rnd%0d_taken", t), 32'(dut_taken), 32'(model_taken));
      compare_regs($sformatf("rnd%0d", t));
      compare_mem($sformatf("rnd%0d", t), 100, 115);
      check_frozen($sformatf("rnd%0d", t));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
